// File: rtl/regfile_pkg.sv
// Shared types and constants for the vector register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned VEC_SIZE      = 4;
    localparam int unsigned REGISTER_SIZE = 8;
    localparam int unsigned REG_COUNT     = 16;
    localparam int unsigned REG_ADDR_SIZE = 4;
    localparam int unsigned PENDING_MAX   = 3;

    typedef logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] laneVec_t;
    typedef logic [REG_ADDR_SIZE-1:0]               regAddr_t;
    typedef logic [1:0]                             pendCount_t;

    localparam regAddr_t ZERO_REG = '0;

endpackage

// File: rtl/pending_counter.sv
// Two-bit saturating up/down counter tracking in-flight writes to one register; clear wins.
module pending_counter
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output pendCount_t count
);

    pendCount_t countNext;

    always_comb begin
        countNext = count;
        if (clr) begin
            countNext = '0;
        end else if (inc && !dec && count != 2'(PENDING_MAX)) begin
            countNext = count + 2'd1;
        end else if (dec && !inc && count != 2'd0) begin
            countNext = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: two bypassed read ports, one write port, per-register pending-write hazard scoreboard.
// Optional debug read port enabled by defining REGFILE_DEBUG_PORT_EN.
module vector_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned vecSize      = VEC_SIZE,
    parameter int unsigned registerSize = REGISTER_SIZE,
    parameter int unsigned regCount     = REG_COUNT,
    parameter int unsigned regAddrSize  = REG_ADDR_SIZE
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      writeEnable,
    input  logic [regAddrSize-1:0]                    writeAddress,
    input  logic [vecSize-1:0][registerSize-1:0]      writeBackData,
    input  logic [regAddrSize-1:0]                    readAddrA,
    input  logic [regAddrSize-1:0]                    readAddrB,
    output logic [vecSize-1:0][registerSize-1:0]      readDataA,
    output logic [vecSize-1:0][registerSize-1:0]      readDataB,
    input  logic                                      issueValid,
    input  logic                                      issueWrites,
    input  logic [regAddrSize-1:0]                    issueDest,
    input  logic                                      flush,
    output logic                                      hazardStall
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [regAddrSize-1:0]                    dbgAddr,
    output logic [vecSize-1:0][registerSize-1:0]      dbgData,
    output logic [1:0]                                dbgPendingCount
`endif
);

    localparam logic [regAddrSize-1:0] zeroAddr = regAddrSize'(ZERO_REG);

    logic [vecSize-1:0][registerSize-1:0] regs [regCount];
    logic [regCount-1:0][1:0]             pend;
    logic writeLive;
    logic retireA;
    logic retireB;
    logic busyA;
    logic busyB;
    logic destFull;
    logic issueInc;

    assign writeLive = writeEnable && (writeAddress != zeroAddr);
    assign retireA   = writeEnable && (writeAddress == readAddrA);
    assign retireB   = writeEnable && (writeAddress == readAddrB);

    // Register 0 is never written, so its storage stays at the reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < int'(regCount); r++) begin
                regs[r] <= '0;
            end
        end else if (writeLive) begin
            regs[writeAddress] <= writeBackData;
        end
    end

    always_comb begin
        readDataA = regs[readAddrA];
        if (readAddrA == zeroAddr) begin
            readDataA = '0;
        end else if (retireA) begin
            readDataA = writeBackData;
        end
    end

    always_comb begin
        readDataB = regs[readAddrB];
        if (readAddrB == zeroAddr) begin
            readDataB = '0;
        end else if (retireB) begin
            readDataB = writeBackData;
        end
    end

    // A single outstanding write retiring this cycle is covered by the bypass, so it is not a hazard.
    always_comb begin
        busyA       = (pend[readAddrA] > 2'd1) || ((pend[readAddrA] == 2'd1) && !retireA);
        busyB       = (pend[readAddrB] > 2'd1) || ((pend[readAddrB] == 2'd1) && !retireB);
        destFull    = issueWrites && (pend[issueDest] == 2'(PENDING_MAX));
        hazardStall = issueValid && (busyA || busyB || destFull);
        issueInc    = issueValid && issueWrites && !hazardStall;
    end

    assign pend[0] = '0;

    for (genvar r = 1; r < int'(regCount); r++) begin : gPend
        pending_counter uCount (
            .clk   (clk),
            .reset (reset),
            .inc   (issueInc && (issueDest == regAddrSize'(r))),
            .dec   (writeEnable && (writeAddress == regAddrSize'(r))),
            .clr   (flush),
            .count (pend[r])
        );
    end

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbgData         = regs[dbgAddr];
    assign dbgPendingCount = pend[dbgAddr];
`endif

endmodule

// File: tb/tb_vector_register_file.sv
// Scoreboard bench for vector_register_file: driver queues expectations, negedge monitor compares.
module tb_vector_register_file;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       writeEnable;
    regAddr_t   writeAddress;
    laneVec_t   writeBackData;
    regAddr_t   readAddrA;
    regAddr_t   readAddrB;
    laneVec_t   readDataA;
    laneVec_t   readDataB;
    logic       issueValid;
    logic       issueWrites;
    regAddr_t   issueDest;
    logic       flush;
    logic       hazardStall;
`ifdef REGFILE_DEBUG_PORT_EN
    regAddr_t   dbgAddr;
    laneVec_t   dbgData;
    logic [1:0] dbgPendingCount;
`endif

    typedef enum {kRdA, kRdB, kStall, kDbgData, kDbgCnt} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } sbEntry_t;

    sbEntry_t    sb[$];
    sbEntry_t    ent;
    logic [31:0] act;
    int          checks = 0;
    int          errors = 0;

    vector_register_file dut (
        .clk           (clk),
        .reset         (reset),
        .writeEnable   (writeEnable),
        .writeAddress  (writeAddress),
        .writeBackData (writeBackData),
        .readAddrA     (readAddrA),
        .readAddrB     (readAddrB),
        .readDataA     (readDataA),
        .readDataB     (readDataB),
        .issueValid    (issueValid),
        .issueWrites   (issueWrites),
        .issueDest     (issueDest),
        .flush         (flush),
        .hazardStall   (hazardStall)
`ifdef REGFILE_DEBUG_PORT_EN
        ,
        .dbgAddr         (dbgAddr),
        .dbgData         (dbgData),
        .dbgPendingCount (dbgPendingCount)
`endif
    );

    always #5 clk = ~clk;

    // Outputs are presented combinationally; compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            ent = sb.pop_front();
            case (ent.kind)
                kRdA:     act = 32'(readDataA);
                kRdB:     act = 32'(readDataB);
                kStall:   act = 32'(hazardStall);
`ifdef REGFILE_DEBUG_PORT_EN
                kDbgData: act = 32'(dbgData);
                kDbgCnt:  act = 32'(dbgPendingCount);
`endif
                default:  act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (act !== ent.exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h at %0t", ent.name, act, ent.exp, $time);
            end
        end
    end

    task automatic want(input kind_t k, input logic [31:0] v, input string n);
        sb.push_back('{kind: k, exp: v, name: n});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeEnable   = 1'b0;
        writeAddress  = '0;
        writeBackData = '0;
        readAddrA     = '0;
        readAddrB     = '0;
        issueValid    = 1'b0;
        issueWrites   = 1'b0;
        issueDest     = '0;
        flush         = 1'b0;
`ifdef REGFILE_DEBUG_PORT_EN
        dbgAddr       = '0;
`endif
    endtask

    task automatic doWrite(input regAddr_t a, input logic [31:0] d);
        writeEnable   = 1'b1;
        writeAddress  = a;
        writeBackData = laneVec_t'(d);
    endtask

    task automatic doIssue(input logic w, input regAddr_t d);
        issueValid  = 1'b1;
        issueWrites = w;
        issueDest   = d;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        readAddrA = 4'd3;
        want(kRdA, 32'h0, "resetReadA");
        want(kRdB, 32'h0, "resetReadB");
        want(kStall, 32'h0, "resetStall");
        step();
        reset = 1'b1;
        step();

        // Same-cycle write bypass, then stored value
        idle(); doWrite(4'd5, 32'hAABBCCDD); readAddrA = 4'd5; readAddrB = 4'd5;
        want(kRdA, 32'hAABBCCDD, "bypassA");
        want(kRdB, 32'hAABBCCDD, "bypassB");
        step();
        idle(); readAddrA = 4'd5;
        want(kRdA, 32'hAABBCCDD, "storedA");
        step();

        // Register 0 ignores writes and never accrues pending counts
        idle(); doWrite(4'd0, 32'hFFFFFFFF);
        want(kRdA, 32'h0, "zeroBypass");
        step();
        for (int i = 0; i < 4; i++) begin
            idle(); doIssue(1'b1, 4'd0);
            want(kRdA, 32'h0, "zeroStored");
            want(kStall, 32'h0, "zeroDestNoStall");
            step();
        end

        // RAW hazard on reg 7 and its clearing by a retiring write
        idle(); doIssue(1'b1, 4'd7); readAddrA = 4'd1; readAddrB = 4'd2;
        want(kStall, 32'h0, "issue7");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrA = 4'd7;
        want(kStall, 32'h1, "hazard7");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrA = 4'd7; doWrite(4'd7, 32'h01020304);
        want(kStall, 32'h0, "retire7NoStall");
        want(kRdA, 32'h01020304, "retire7Bypass");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrA = 4'd7;
        want(kStall, 32'h0, "pend7Cleared");
        want(kRdA, 32'h01020304, "stored7");
        step();

        // Saturation of reg 9 at three pending writes
        for (int i = 0; i < 3; i++) begin
            idle(); doIssue(1'b1, 4'd9);
            want(kStall, 32'h0, "issue9");
            step();
        end
        idle(); doIssue(1'b1, 4'd9);
        want(kStall, 32'h1, "saturate9");
        step();
        idle(); doWrite(4'd9, 32'h99887766); readAddrB = 4'd9;
        want(kRdB, 32'h99887766, "write9Bypass");
        want(kStall, 32'h0, "noIssueNoStall");
        step();
        idle(); doIssue(1'b1, 4'd9); doWrite(4'd9, 32'h12345678);
        want(kStall, 32'h0, "incDecSame");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrB = 4'd9;
        want(kStall, 32'h1, "pend9Is2");
        want(kRdB, 32'h12345678, "stored9");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrB = 4'd9; doWrite(4'd9, 32'h0A0B0C0D);
        want(kStall, 32'h1, "pend9Is2Retire");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrB = 4'd9;
        want(kStall, 32'h1, "pend9Is1");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrB = 4'd9; doWrite(4'd9, 32'h5A5A5A5A);
        want(kStall, 32'h0, "pend9LastRetire");
        want(kRdB, 32'h5A5A5A5A, "pend9LastBypass");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrB = 4'd9;
        want(kStall, 32'h0, "pend9Is0");
        step();

        // Flush clears all counts, beats a same-cycle issue, and keeps the write
        for (int i = 0; i < 3; i++) begin
            idle(); doIssue(1'b1, (i == 2) ? 4'd4 : 4'd2);
            want(kStall, 32'h0, "issueBeforeFlush");
            step();
        end
        idle(); flush = 1'b1; doIssue(1'b1, 4'd2); doWrite(4'd6, 32'h66666666);
        want(kStall, 32'h0, "flushCycle");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrA = 4'd2; readAddrB = 4'd4;
        want(kStall, 32'h0, "afterFlush");
`ifdef REGFILE_DEBUG_PORT_EN
        dbgAddr = 4'd2;
        want(kDbgCnt, 32'h0, "dbgCount2");
`endif
        step();
        idle(); readAddrA = 4'd6;
        want(kRdA, 32'h66666666, "flushWriteKept");
`ifdef REGFILE_DEBUG_PORT_EN
        dbgAddr = 4'd4;
        want(kDbgCnt, 32'h0, "dbgCount4");
`endif
        step();
`ifdef REGFILE_DEBUG_PORT_EN
        idle(); dbgAddr = 4'd6; doWrite(4'd6, 32'h11111111);
        want(kDbgData, 32'h66666666, "dbgNoBypass");
        step();
`endif

        // Reset mid-run clears data and pending counts immediately
        idle(); doWrite(4'd3, 32'h11223344); doIssue(1'b1, 4'd3);
        want(kStall, 32'h0, "issue3a");
        step();
        idle(); doIssue(1'b1, 4'd3);
        want(kStall, 32'h0, "issue3b");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrA = 4'd3;
        want(kStall, 32'h1, "hazard3");
        want(kRdA, 32'h11223344, "stored3");
        step();
        reset = 1'b0;
`ifdef REGFILE_DEBUG_PORT_EN
        dbgAddr = 4'd3;
        want(kDbgData, 32'h0, "dbgInReset");
`endif
        want(kRdA, 32'h0, "midResetRead");
        want(kStall, 32'h0, "midResetStall");
        step();
        reset = 1'b1;
        want(kRdA, 32'h0, "postResetRead");
        want(kStall, 32'h0, "postResetStall");
        step();
        idle(); doWrite(4'd3, 32'hCAFEF00D); readAddrA = 4'd3;
        want(kRdA, 32'hCAFEF00D, "postResetBypass");
        step();
        idle(); doIssue(1'b0, 4'd0); readAddrA = 4'd3;
        want(kRdA, 32'hCAFEF00D, "postResetStored");
        want(kStall, 32'h0, "postResetNoStall");
        step();

        idle();
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboardDrain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_register_file.md
Name: vector_register_file

Overview:
- Vector register file that consumes the writeback stage's per-lane result and writes it back on the architectural write port.
- Provides two combinational read ports to decode, with same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard: it raises a hazard stall when decode reads a register whose write has not yet retired.

Parameters:
- vecSize, 4, lanes per vector.
- registerSize, 8, bits per lane.
- regCount, 16, number of vector registers; register 0 is hardwired zero.
- regAddrSize, 4, register address width; must equal clog2(regCount).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- writeEnable  input  1  writeback write strobe.
- writeAddress  input  regAddrSize  destination register of the writeback.
- writeBackData  input  vecSize x registerSize  data from the writeback stage.
- readAddrA  input  regAddrSize  source A address from decode.
- readAddrB  input  regAddrSize  source B address from decode.
- readDataA  output  vecSize x registerSize  source A data.
- readDataB  output  vecSize x registerSize  source B data.
- issueValid  input  1  decode is issuing an instruction this cycle.
- issueWrites  input  1  the issuing instruction writes a register.
- issueDest  input  regAddrSize  destination of the issuing instruction.
- flush  input  1  pipeline flush; discards all pending entries.
- hazardStall  output  1  decode must hold the current instruction.

Behaviour:
- Reset (reset low, asynchronous): all registers = 0, all pending counters = 0, so hazardStall = 0 and both read ports return 0.
- Write: on posedge, if writeEnable and writeAddress != 0, then reg[writeAddress] <= writeBackData. Writes to address 0 are ignored.
- Read: combinational.
  - Address 0 returns all zeros.
  - Bypass: if writeEnable and writeAddress == readAddr (!= 0), return writeBackData.
  - Otherwise return the stored register.
- Pending counter: 2-bit per register, range 0..3, register 0 always 0.
  - Increment when issueValid & issueWrites & !hazardStall & issueDest == r, r != 0.
  - Decrement when writeEnable & writeAddress == r.
  - Increment and decrement on the same register in the same cycle: count unchanged.
  - Decrement at 0: stays 0 (spurious write, no underflow).
- Effective busy for source s: pend[s] > 1, or (pend[s] == 1 and not (writeEnable and writeAddress == s)).
  - A write retiring this cycle clears the hazard for that source via the bypass.
- hazardStall (combinational) = issueValid & (busy(readAddrA) | busy(readAddrB) | (issueWrites & pend[issueDest] == 3)).
  - Saturation at 3 stalls issue; the counter never wraps.
- Flush: on posedge, all counters <= 0. Flush has priority over increment and decrement in that cycle. The register write in that cycle still occurs.
- Latency: write-to-read is 0 cycles (bypass). Counter updates are visible from the next cycle.
- Reset asserted mid-operation: immediate clear. The first edge after reset deassert behaves normally.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- With the macro defined:
  - Adds input dbgAddr (regAddrSize) and output dbgData (vecSize x registerSize).
  - dbgData returns the stored register combinationally, with no bypass. dbgData is 0 during reset.
  - Adds output dbgPendingCount (2 bits) = pend[dbgAddr].
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package regfile_pkg holds:
  - localparam PENDING_MAX = 3;
  - the lane vector typedef (vecSize x registerSize);
  - the register address typedef;
  - the constant ZERO_REG = 0.
- One sub-module, pending_counter: 2-bit saturating up/down counter.
  - Ports: clk, reset, inc, dec, clr, count.
  - Instantiated regCount-1 times in a generate loop.

Test Plan:
1. Reset low mid-run with reg 3 = 0x11223344 and pend[3] = 2 -> readDataA (addr 3) = 0 and hazardStall = 0 immediately; after deassert, still 0 and no stall.
2. writeEnable = 1, writeAddress = 5, writeBackData = 0xAABBCCDD, readAddrA = 5 in the same cycle -> readDataA = 0xAABBCCDD combinationally; next cycle, with no write, it still reads 0xAABBCCDD.
3. Write 0xFFFFFFFF to address 0 -> readDataA (addr 0) = 0 before and after the edge; pend[0] stays 0 when issueDest = 0.
4. Issue with dest 7 (pend = 1); next cycle read A = 7 -> hazardStall = 1. Same read with writeEnable to 7 in that cycle -> hazardStall = 0 and bypassed data returned; after that edge, pend[7] = 0.
5. Issue to dest 9 in three consecutive cycles (pend = 3); a fourth issue to 9 -> hazardStall = 1 and pend stays 3. Simultaneous issue to 9 and write to 9 at pend = 2 -> pend stays 2.
6. pend[2] = 2 and pend[4] = 1, assert flush together with an issue to dest 2 -> after the edge, all counts = 0; with REGFILE_DEBUG_PORT_EN, dbgPendingCount for 2 and for 4 reads 0.
